fb_port_arbiter: RTL and testbench

Arbiter for the single-port 320x240 frame-buffer BRAM, shared between the OV7670 capture writer and the VGA display reader. Display reads get strict priority and a fixed latency. Capture writes are queued in a small FIFO and drained into cycles where no read is issued. The block sits between the capture/address-generation logic and the frame-buffer memory instance.

---
 rtl/fb_pkg.sv | 21 ++
 rtl/fb_wr_fifo.sv | 59 +++++
 rtl/fb_port_arbiter.sv | 140 ++++++++++++++
 tb/tb_fb_port_arbiter.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared definitions for the 320x240 RGB444 frame buffer and its port arbiter.
package fb_pkg;

    localparam int FB_W     = 320;
    localparam int FB_H     = 240;
    localparam int FB_DEPTH = FB_W * FB_H;
    localparam int ADDR_W   = 17;
    localparam int DATA_W   = 12;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_req_t;

    typedef enum logic [1:0] {
        GRANT_IDLE,
        GRANT_READ,
        GRANT_WRITE
    } grant_t;

endpackage

// File: rtl/fb_wr_fifo.sv
// Small synchronous FIFO holding capture write requests until the memory port is free.
module fb_wr_fifo
    import fb_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  wr_req_t          push_data,
    input  logic             pop,
    output wr_req_t          head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    wr_req_t          entries [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = entries[rd_ptr];

    // Storage needs no reset: an entry is only visible once the count covers it.
    always_ff @(posedge clk) begin
        if (do_push) begin
            entries[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fb_port_arbiter.sv
// Single-port frame-buffer arbiter: display reads win every cycle they ask,
// capture writes wait in a FIFO and drain into cycles with no read.
module fb_port_arbiter
    import fb_pkg::*;
#(
    parameter int ADDR_W     = fb_pkg::ADDR_W,
    parameter int DATA_W     = fb_pkg::DATA_W,
    parameter int FB_DEPTH   = fb_pkg::FB_DEPTH,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              stat_clr,
    output logic              err_addr,
    output logic [15:0]       wr_stall_cnt
);

    localparam int                CNT_W      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(FB_DEPTH);
    localparam logic [CNT_W-1:0]  CNT_MAX    = CNT_W'(FIFO_DEPTH);

    grant_t           grant;
    logic             rd_in_range;
    logic             wr_in_range;
    logic             rd_oor;
    logic             wr_accept;
    logic             wr_push;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    wr_req_t          push_req;
    wr_req_t          head_req;
    logic             s1_issued;
    logic             s1_oor;

    assign rd_in_range = (rd_addr < ADDR_LIMIT);
    assign wr_in_range = (wr_addr < ADDR_LIMIT);
    assign rd_oor      = rst_n && rd_req && !rd_in_range;
    // No ready-from-pop path: a full queue refuses even when it drains this cycle.
    assign wr_ready    = rst_n && !fifo_full;
    assign wr_accept   = wr_valid && wr_ready;
    assign wr_push     = wr_accept && wr_in_range;
    assign push_req    = '{addr: wr_addr, data: wr_data};

    fb_wr_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_wr_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (wr_push),
        .push_data(push_req),
        .pop      (grant == GRANT_WRITE),
        .head     (head_req),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    always_comb begin
        grant = GRANT_IDLE;
        if (rst_n) begin
            if (rd_req && rd_in_range) begin
                grant = GRANT_READ;
            end else if (!fifo_empty) begin
                grant = GRANT_WRITE;
            end
        end
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (grant)
            GRANT_READ: begin
                mem_en   = 1'b1;
                mem_addr = rd_addr;
            end
            GRANT_WRITE: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = head_req.addr;
                mem_wdata = head_req.data;
            end
            default: begin
                mem_en = 1'b0;
            end
        endcase
    end

    // Out-of-range reads still travel the pipeline so the display sees a fixed latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_issued <= 1'b0;
            s1_oor    <= 1'b0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
        end else begin
            s1_issued <= rd_req;
            s1_oor    <= rd_req && !rd_in_range;
            rd_valid  <= s1_issued;
            rd_data   <= (s1_issued && !s1_oor) ? mem_rdata : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_addr     <= 1'b0;
            wr_stall_cnt <= '0;
        end else if (stat_clr) begin
            err_addr     <= 1'b0;
            wr_stall_cnt <= '0;
        end else begin
            if (rd_oor || (wr_accept && !wr_in_range)) begin
                err_addr <= 1'b1;
            end
            if (wr_valid && !wr_ready && (wr_stall_cnt != 16'hFFFF)) begin
                wr_stall_cnt <= wr_stall_cnt + 16'd1;
            end
        end
    end

    assert property (@(posedge clk) disable iff (!rst_n)
        (fifo_count <= CNT_MAX) && (fifo_full == (fifo_count == CNT_MAX)));

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Scoreboard bench for fb_port_arbiter with a behavioural frame-buffer BRAM.
module tb_fb_port_arbiter;

    localparam int ADDR_W   = 17;
    localparam int DATA_W   = 12;
    localparam int FB_DEPTH = 76800;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              rd_req = 1'b0;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              wr_valid = 1'b0;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              stat_clr = 1'b0;
    logic              err_addr;
    logic [15:0]       wr_stall_cnt;

    int num_checks = 0;
    int num_errs   = 0;
    int acc_cnt    = 0;
    int acc_base;

    logic [DATA_W-1:0]        rd_q [$];
    logic [ADDR_W+DATA_W-1:0] wr_q [$];
    logic [DATA_W-1:0]        fb_mem [0:FB_DEPTH-1];

    fb_port_arbiter #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .FB_DEPTH  (FB_DEPTH),
        .FIFO_DEPTH(4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rd_req      (rd_req),
        .rd_addr     (rd_addr),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .stat_clr    (stat_clr),
        .err_addr    (err_addr),
        .wr_stall_cnt(wr_stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] pixelAt(input int a);
        logic [31:0] v;
        v = a * 37 + 5;
        if (a == 100) begin
            return 12'hABC;
        end
        return v[DATA_W-1:0];
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        num_checks++;
        if (actual !== expected) begin
            num_errs++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic r_req, input logic [ADDR_W-1:0] r_addr,
                                 input logic w_valid, input logic [ADDR_W-1:0] w_addr,
                                 input logic [DATA_W-1:0] w_data, input logic s_clr);
        @(posedge clk);
        #1;
        rd_req   = r_req;
        rd_addr  = r_addr;
        wr_valid = w_valid;
        wr_addr  = w_addr;
        wr_data  = w_data;
        stat_clr = s_clr;
        @(negedge clk);
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0);
    endtask

    // Frame-buffer BRAM: one-cycle read latency.
    initial begin
        for (int i = 0; i < FB_DEPTH; i++) begin
            fb_mem[i] = pixelAt(i);
        end
    end

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                fb_mem[mem_addr] <= mem_wdata;
            end else begin
                mem_rdata <= fb_mem[mem_addr];
            end
        end
    end

    // Scoreboard: compare what leaves the DUT, then queue what was just offered.
    always @(negedge clk) begin
        logic [DATA_W-1:0]        exp_rd;
        logic [ADDR_W+DATA_W-1:0] exp_wr;
        if (rd_valid) begin
            if (rd_q.size() == 0) begin
                checkOutput("rd_unexpected", 32'd1, 32'd0);
            end else begin
                exp_rd = rd_q.pop_front();
                checkOutput("sb_rd_data", 32'(rd_data), 32'(exp_rd));
            end
        end
        if (mem_en && mem_we) begin
            if (wr_q.size() == 0) begin
                checkOutput("we_unexpected", 32'd1, 32'd0);
            end else begin
                exp_wr = wr_q.pop_front();
                checkOutput("sb_wr_req", 32'({mem_addr, mem_wdata}), 32'(exp_wr));
            end
        end
        if (!rst_n) begin
            rd_q.delete();
            wr_q.delete();
        end else begin
            if (rd_req) begin
                rd_q.push_back((rd_addr < ADDR_W'(FB_DEPTH)) ? pixelAt(int'(rd_addr)) : '0);
            end
            if (wr_valid && wr_ready) begin
                acc_cnt++;
                if (wr_addr < ADDR_W'(FB_DEPTH)) begin
                    wr_q.push_back({wr_addr, wr_data});
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset held with random inputs.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 90000)),
                          1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 90000)),
                          DATA_W'($urandom), 1'($urandom_range(0, 1)));
            checkOutput("rst_mem_en", 32'(mem_en), 32'd0);
            checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
            checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
            checkOutput("rst_mem_wdata", 32'(mem_wdata), 32'd0);
            checkOutput("rst_rd_valid", 32'(rd_valid), 32'd0);
            checkOutput("rst_rd_data", 32'(rd_data), 32'd0);
            checkOutput("rst_wr_ready", 32'(wr_ready), 32'd0);
            checkOutput("rst_err", 32'(err_addr), 32'd0);
            checkOutput("rst_stall", 32'(wr_stall_cnt), 32'd0);
        end
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        rd_req   = 1'b0;
        wr_valid = 1'b0;
        stat_clr = 1'b0;
        @(negedge clk);
        checkOutput("rel_wr_ready", 32'(wr_ready), 32'd1);
        checkOutput("rel_mem_en", 32'(mem_en), 32'd0);

        // Single read, then a back-to-back burst of 8.
        applyStimulus(1'b1, ADDR_W'(100), 1'b0, '0, '0, 1'b0);
        checkOutput("rd_mem_en", 32'(mem_en), 32'd1);
        checkOutput("rd_mem_we", 32'(mem_we), 32'd0);
        checkOutput("rd_mem_addr", 32'(mem_addr), 32'd100);
        idleCycle();
        checkOutput("rd_early_valid", 32'(rd_valid), 32'd0);
        idleCycle();
        checkOutput("rd_valid", 32'(rd_valid), 32'd1);
        checkOutput("rd_data", 32'(rd_data), 32'hABC);
        for (int i = 0; i <= 10; i++) begin
            applyStimulus(i < 8, ADDR_W'(200 + i), 1'b0, '0, '0, 1'b0);
            if (i >= 2) begin
                checkOutput("b2b_valid", 32'(rd_valid), (i < 10) ? 32'd1 : 32'd0);
            end
        end

        // Single write into an idle port.
        applyStimulus(1'b0, '0, 1'b1, ADDR_W'(5), 12'h123, 1'b0);
        checkOutput("wr_accept_ready", 32'(wr_ready), 32'd1);
        checkOutput("wr_not_same_cycle", 32'(mem_we), 32'd0);
        idleCycle();
        checkOutput("wr_mem_en", 32'(mem_en), 32'd1);
        checkOutput("wr_mem_we", 32'(mem_we), 32'd1);
        checkOutput("wr_mem_addr", 32'(mem_addr), 32'd5);
        checkOutput("wr_mem_wdata", 32'(mem_wdata), 32'h123);
        idleCycle();
        checkOutput("wr_done_idle", 32'(mem_en), 32'd0);

        // Reads hold the port for 10 cycles while writes keep coming.
        acc_base = acc_cnt;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, ADDR_W'(300 + i), 1'b1, ADDR_W'(1000 + i), DATA_W'(12'h500 + i), 1'b0);
            checkOutput("burst_no_we", 32'(mem_we), 32'd0);
        end
        for (int k = 0; k < 4; k++) begin
            idleCycle();
            if (k == 0) begin
                checkOutput("burst_accepted", 32'(acc_cnt - acc_base), 32'd4);
                checkOutput("burst_stall_cnt", 32'(wr_stall_cnt), 32'd6);
            end
            checkOutput("drain_we", 32'(mem_we), 32'd1);
            checkOutput("drain_addr", 32'(mem_addr), 32'(1000 + k));
            checkOutput("drain_data", 32'(mem_wdata), 32'(12'h500 + k));
        end
        idleCycle();
        checkOutput("drain_done", 32'(mem_we), 32'd0);

        // Out-of-range read and write.
        applyStimulus(1'b1, ADDR_W'(76800), 1'b0, '0, '0, 1'b0);
        checkOutput("oor_rd_no_en", 32'(mem_en), 32'd0);
        idleCycle();
        idleCycle();
        checkOutput("oor_rd_valid", 32'(rd_valid), 32'd1);
        checkOutput("oor_rd_data", 32'(rd_data), 32'd0);
        checkOutput("oor_rd_err", 32'(err_addr), 32'd1);
        applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b1);
        idleCycle();
        checkOutput("clr_err", 32'(err_addr), 32'd0);
        checkOutput("clr_stall", 32'(wr_stall_cnt), 32'd0);
        applyStimulus(1'b0, '0, 1'b1, ADDR_W'(80000), 12'h777, 1'b0);
        checkOutput("oor_wr_ready", 32'(wr_ready), 32'd1);
        idleCycle();
        checkOutput("oor_wr_no_en", 32'(mem_en), 32'd0);
        checkOutput("oor_wr_err", 32'(err_addr), 32'd1);
        idleCycle();
        checkOutput("oor_wr_err_sticky", 32'(err_addr), 32'd1);
        applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b1);
        idleCycle();
        checkOutput("clr_err2", 32'(err_addr), 32'd0);

        // Reset in the middle of a read burst with writes queued.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, ADDR_W'(400 + i), i < 3, ADDR_W'(3000 + i), DATA_W'(12'h600 + i), 1'b0);
        end
        @(posedge clk);
        #1;
        rst_n    = 1'b0;
        rd_req   = 1'b0;
        wr_valid = 1'b0;
        @(negedge clk);
        checkOutput("mid_rst_wr_ready", 32'(wr_ready), 32'd0);
        checkOutput("mid_rst_mem_en", 32'(mem_en), 32'd0);
        checkOutput("mid_rst_rd_valid", 32'(rd_valid), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("post_rst_wr_ready", 32'(wr_ready), 32'd1);
        for (int i = 0; i < 6; i++) begin
            idleCycle();
            checkOutput("post_rst_no_we", 32'(mem_we), 32'd0);
            checkOutput("post_rst_no_valid", 32'(rd_valid), 32'd0);
        end

        checkOutput("rd_q_left", 32'(rd_q.size()), 32'd0);
        checkOutput("wr_q_left", 32'(wr_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_checks, num_errs);
        $finish;
    end

endmodule
